// File: rtl/dmem_pkg.sv
// Shared data-memory types: FSM states, sizing constants, error reasons.
// Combinational helper only; no latency or backpressure of its own.
package dmem_pkg;

  localparam int DMEM_WAIT_W     = 4;
  localparam int DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } dmem_state_t;

  // Error reasons; the MEM stage decodes the same encoding.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } dmem_err_t;

  function automatic dmem_err_t dmem_check(input logic [31:0] addr, input int aw);
    logic [31:0] word;
    word = addr >> 2;
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if ((word >> aw) != 32'd0) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM, write-first read; byte-lane writes with DMEM_BYTE_ENABLE_EN.
// Latency: read data registered one edge after en; no backpressure.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [31:0]                wdata,
  input  logic [DMEM_WORD_BYTES-1:0] be,
  output logic [31:0]                rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

`ifdef DMEM_BYTE_ENABLE_EN
  logic [31:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= merged;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then word access (DMEM_BYTE_ENABLE_EN selects lane writes).
// Latency: response valid WAIT_CYCLES+2 cycles after acceptance; response held until resp_ready, req_ready low while busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t            state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [3:0]             be_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   load_q;
  logic                   accept;
  logic                   addr_ok;
  logic                   arr_en;
  logic [31:0]            arr_rdata;
  dmem_err_t              err_code;

  assign err_code = dmem_check(addr_q, ADDR_WIDTH);
  assign addr_ok  = (err_code == ERR_NONE);
  assign accept   = (state_q == ST_IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    arr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (req_valid) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_RESP;
        arr_en  = addr_ok;
      end
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt_q   <= WAIT_LOAD;
        ready_q <= 1'b0;
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == ST_ACCESS) begin
        valid_q <= 1'b1;
        err_q   <= ~addr_ok;
        load_q  <= addr_ok & ~we_q;
      end
      if (state_q == ST_RESP && resp_ready) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        load_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (we_q),
    .addr  (addr_q[ADDR_WIDTH+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (arr_rdata)
  );

  // RAM output register only moves in ACCESS; load_q gates it to 0 outside load responses.
  assign resp_rdata = load_q ? arr_rdata : 32'd0;
  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance checked every cycle against a request-level model.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam logic [31:0] BE_EXP =
`ifdef DMEM_BYTE_ENABLE_EN
    32'hDEADBEAA;
`else
    32'h000000AA;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // Request-level model: one outstanding request, access WAIT+1 edges after acceptance.
  bit        busy[2];
  bit        erv [2];
  bit        eer [2];
  bit [31:0] erd [2];
  int        age [2];
  bit        mwe [2];
  bit [31:0] ma  [2];
  bit [31:0] mwd [2];
  bit [3:0]  mbe [2];
  bit [31:0] mm  [2][1024];
  bit        take;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_access(input int i);
    int w;
    w = int'(ma[i] >> 2);
    erv[i] = 1'b1;
    if (ma[i][1:0] != 2'b00 || ma[i] >= (32'd4 << AW)) begin
      eer[i] = 1'b1;
      erd[i] = 32'd0;
    end else if (mwe[i]) begin
`ifdef DMEM_BYTE_ENABLE_EN
      for (int b = 0; b < 4; b++) if (mbe[i][b]) mm[i][w][8*b +: 8] = mwd[i][8*b +: 8];
`else
      mm[i][w] = mwd[i];
`endif
      eer[i] = 1'b0;
      erd[i] = 32'd0;
    end else begin
      eer[i] = 1'b0;
      erd[i] = mm[i][w];
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 1'b0; erv[i] = 1'b0; eer[i] = 1'b0; erd[i] = 32'd0;
      end else begin
        take = !busy[i] && req_valid[i];
        if (busy[i] && !erv[i]) begin
          age[i]++;
          if (age[i] == wc(i) + 1) model_access(i);
        end else if (erv[i] && resp_ready[i]) begin
          erv[i] = 1'b0; eer[i] = 1'b0; erd[i] = 32'd0; busy[i] = 1'b0;
        end
        if (take) begin
          busy[i] = 1'b1; age[i] = 0;
          mwe[i] = req_we[i]; ma[i] = req_addr[i]; mwd[i] = req_wdata[i]; mbe[i] = req_be[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("req_ready",  i, 32'(req_ready[i]),  32'(!busy[i]));
      chk("resp_valid", i, 32'(resp_valid[i]), 32'(erv[i]));
      chk("resp_rdata", i, resp_rdata[i],      erd[i]);
      chk("resp_err",   i, 32'(resp_err[i]),   32'(eer[i]));
    end
  end

  task automatic die(input string nm, input int d);
    vectors++;
    miscompares++;
    $display("FAIL %s dut%0d: handshake never came, expected within 100 cycles", nm, d);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic send(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_be[i] = be; req_valid[i] = 1'b1;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) die("req_accept", i);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    acc = ecnt;
  endtask

  task automatic recv(input int i, input int hold, output logic [31:0] rd, output logic er,
                      output int lat, output int hs);
    lat = 0;
    resp_ready[i] = (hold == 0);
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[i] && lat < 100);
    if (!resp_valid[i]) die("resp_wait", i);
    repeat (hold) @(negedge clk);
    rd = resp_rdata[i];
    er = resp_err[i];
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    hs = ecnt;
  endtask

  task automatic op(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] be, output logic [31:0] rd, output logic er,
                    output int lat, output int acc);
    int hs;
    send(i, we, a, wd, be, acc);
    recv(i, 0, rd, er, lat, hs);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, hs, acc_prev;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_be[i] = '0; resp_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  0, 32'(req_ready[0]),  32'd1);
    chk("rst_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_rdata", 0, resp_rdata[0],      32'd0);
    chk("rst_resp_err",   0, 32'(resp_err[0]),   32'd0);
    #2 rst = 1'b0;

    op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, acc);
    chk("store_latency", 0, lat, 32'd4);
    chk("store_err", 0, 32'(er), 32'd0);
    op(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, acc);
    chk("load_rdata", 0, rd, 32'hDEADBEEF);
    chk("load_latency", 0, lat, 32'd4);

    op(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat, acc);
    op(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, acc);
    chk("byte_enable_rdata", 0, rd, BE_EXP);

    op(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, acc);
    chk("misalign_err", 0, 32'(er), 32'd1);
    chk("misalign_rdata", 0, rd, 32'd0);

    op(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, acc);
    op(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat, acc);
    chk("range_err", 0, 32'(er), 32'd1);
    op(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, acc);
    chk("range_no_write", 0, rd, 32'hCAFEF00D);

    // Back-pressure with a second request waiting behind the first.
    send(0, 1'b0, 32'h10, 32'h0, 4'hF, acc);
    req_we[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'h0BADCAFE;
    req_be[0] = 4'hF; req_valid[0] = 1'b1;
    recv(0, 5, rd, er, lat, hs);
    chk("bp_rdata", 0, rd, BE_EXP);
    send(0, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, acc);
    chk("bp_accept_edge", 0, acc, hs + 1);
    recv(0, 0, rd, er, lat, hs);
    op(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, acc);
    chk("bp_second_rdata", 0, rd, 32'h0BADCAFE);

    // Reset while a store sits in WAIT.
    op(0, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat, acc);
    send(0, 1'b1, 32'h20, 32'h22222222, 4'hF, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready",  0, 32'(req_ready[0]),  32'd1);
    chk("midrst_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    op(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, acc);
    chk("midrst_dropped_store", 0, rd, 32'h11111111);

    // Zero wait states: latency 2, one request every 3 cycles.
    op(1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, rd, er, lat, acc);
    chk("w0_store_latency", 1, lat, 32'd2);
    acc_prev = acc;
    op(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat, acc);
    chk("w0_load_rdata", 1, rd, 32'hA5A5A5A5);
    chk("w0_load_latency", 1, lat, 32'd2);
    chk("w0_spacing_1", 1, acc - acc_prev, 32'd3);
    acc_prev = acc;
    op(1, 1'b0, 32'h2, 32'h0, 4'hF, rd, er, lat, acc);
    chk("w0_misalign_err", 1, 32'(er), 32'd1);
    chk("w0_spacing_2", 1, acc - acc_prev, 32'd3);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
